// File: rtl/ppu_mem_pkg.sv
// Shared definitions for the PPU memory preload/verify slice.
//   - channel index constants
//   - loader FSM state enum
//   - pack_entry(): builds a {ch, addr, data} listing word at default widths
//   - LIST_ROM: listing contents used by ppu_mem_list_rom
package ppu_mem_pkg;

  localparam int CH_VRAM  = 0;
  localparam int CH_SPRAM = 1;
  localparam int CH_PAL   = 2;

  // Default field widths of a listing entry
  localparam int PKG_CH_W   = 2;
  localparam int PKG_ADDR_W = 16;
  localparam int PKG_DATA_W = 8;
  localparam int ENTRY_W    = PKG_CH_W + PKG_ADDR_W + PKG_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_CHECK,
    ST_DONE
  } loader_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [PKG_CH_W-1:0]   ch,
    input logic [PKG_ADDR_W-1:0] addr,
    input logic [PKG_DATA_W-1:0] data
  );
    return {ch, addr, data};
  endfunction

  // Listing contents; element [0] is the rightmost term.
  // Entry 3 carries channel 3, which is invalid for a 2-channel loader.
  localparam int LIST_DEPTH = 8;
  localparam logic [LIST_DEPTH-1:0][ENTRY_W-1:0] LIST_ROM = {
    pack_entry(2'(CH_VRAM),  16'h0001, 8'h02),  // 7
    pack_entry(2'(CH_VRAM),  16'h3F00, 8'h0F),  // 6
    pack_entry(2'(CH_SPRAM), 16'h00FF, 8'h80),  // 5
    pack_entry(2'(CH_PAL),   16'h0040, 8'h3C),  // 4
    pack_entry(2'd3,         16'h1234, 8'hAA),  // 3
    pack_entry(2'(CH_SPRAM), 16'h0005, 8'h01),  // 2
    pack_entry(2'(CH_VRAM),  16'h2000, 8'h01),  // 1
    pack_entry(2'(CH_VRAM),  16'h0000, 8'hFF)   // 0
  };

endpackage

// File: rtl/ppu_mem_list_rom.sv
// Synchronous listing ROM, one cycle of read latency, contents from
// ppu_mem_pkg::LIST_ROM. Addresses past the table read as zero.
//   clk  : clock
//   addr : listing address
//   data : entry word, valid the cycle after addr
module ppu_mem_list_rom
  import ppu_mem_pkg::*;
#(
  parameter int AW = 8,
  parameter int W  = ENTRY_W
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  data
);

  localparam int IDX_W = $clog2(LIST_DEPTH);

  always_ff @(posedge clk)
    data <= (int'(addr) < LIST_DEPTH) ? W'(LIST_ROM[addr[IDX_W-1:0]]) : '0;

endmodule

// File: rtl/ppu_mem_loader.sv
// Preload/verify engine for PPU memories. Walks num_entries listing words
// {ch, addr, data}; in load mode writes each to its channel, in verify mode
// reads it back and counts mismatches. Entries naming a channel >= NUM_CH
// issue nothing and count as errors.
//   start/mode/num_entries : pass request (sampled when idle)
//   busy/done              : pass status
//   err_count/first_err_idx: saturating error count, index of first error
//   list_addr/list_data    : listing ROM port (1-cycle latency)
//   mem_*                  : per-channel strobe/addr/data with ready handshake
module ppu_mem_loader
  import ppu_mem_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int LIST_AW = 8,
  parameter int ERR_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           mode,
  input  logic [LIST_AW:0]               num_entries,
  output logic                           busy,
  output logic                           done,
  output logic [ERR_W-1:0]               err_count,
  output logic [LIST_AW-1:0]             first_err_idx,
  output logic [LIST_AW-1:0]             list_addr,
  input  logic [CH_W+ADDR_W+DATA_W-1:0]  list_data,
  output logic [NUM_CH-1:0]              mem_wr_en,
  output logic [NUM_CH-1:0]              mem_rd_en,
  output logic [NUM_CH-1:0][ADDR_W-1:0]  mem_addr,
  output logic [NUM_CH-1:0][DATA_W-1:0]  mem_wdata,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  mem_rdata,
  input  logic [NUM_CH-1:0]              mem_ready
);

  loader_state_t state, state_nx;

  logic               mode_r;
  logic [LIST_AW:0]   idx, num_r, idx_inc;
  logic [CH_W-1:0]    e_ch;
  logic [ADDR_W-1:0]  e_addr;
  logic [DATA_W-1:0]  e_data;
  logic [NUM_CH-1:0]  sel;
  logic               ch_ok, rdy_sel, accept, last, next_ent, inc_err;
  logic [DATA_W-1:0]  rdata_sel;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_hold;
  logic [NUM_CH-1:0][DATA_W-1:0] wdata_hold;

  // ROM address tracks idx directly, so list_data stays stable for the
  // whole ISSUE/CHECK stretch of an entry.
  assign list_addr = idx[LIST_AW-1:0];
  assign {e_ch, e_addr, e_data} = list_data;
  assign idx_inc = idx + 1'b1;
  assign last    = (idx_inc == num_r);

  // Per-channel decode; the channel being issued drives the live entry
  // fields, all others show their last issued values.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel[c]       = (e_ch == CH_W'(c));
    assign mem_addr[c]  = (state == ST_ISSUE && sel[c]) ? e_addr : addr_hold[c];
    assign mem_wdata[c] = (state == ST_ISSUE && sel[c]) ? e_data : wdata_hold[c];

    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        addr_hold[c]  <= '0;
        wdata_hold[c] <= '0;
      end else if (state == ST_ISSUE && sel[c]) begin
        addr_hold[c]  <= e_addr;
        wdata_hold[c] <= e_data;
      end
  end

  assign ch_ok   = |sel;
  assign rdy_sel = |(mem_ready & sel);
  assign accept  = (state == ST_ISSUE) && ch_ok && rdy_sel;

  always_comb begin
    rdata_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (sel[c]) rdata_sel = mem_rdata[c];
  end

  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;

  // Next state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (num_entries == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: state_nx = ST_ISSUE;
      ST_ISSUE:
        if (!ch_ok)      state_nx = last ? ST_DONE : ST_FETCH;
        else if (accept) state_nx = mode_r ? ST_CHECK : (last ? ST_DONE : ST_FETCH);
      ST_CHECK: state_nx = last ? ST_DONE : ST_FETCH;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs: strobes are pure state decode so reset kills them immediately
  always_comb begin
    mem_wr_en = '0;
    mem_rd_en = '0;
    inc_err   = 1'b0;
    next_ent  = 1'b0;
    busy      = state inside {ST_FETCH, ST_ISSUE, ST_CHECK};
    case (state)
      ST_ISSUE:
        if (ch_ok) begin
          if (mode_r) mem_rd_en = sel;
          else        mem_wr_en = sel;
          next_ent = accept && !mode_r;
        end else begin
          inc_err  = 1'b1;
          next_ent = 1'b1;
        end
      ST_CHECK: begin
        inc_err  = (rdata_sel != e_data);
        next_ent = 1'b1;
      end
      default: ;
    endcase
  end

  // Pass bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mode_r        <= 1'b0;
      num_r         <= '0;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      done          <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      mode_r        <= mode;
      num_r         <= num_entries;
      idx           <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      done          <= (num_entries == '0);
    end else begin
      if (next_ent) idx <= idx_inc;
      if (inc_err && err_count != '1) err_count <= err_count + 1'b1;
      if (inc_err && err_count == '0) first_err_idx <= idx[LIST_AW-1:0];
      if (state_nx == ST_DONE) done <= 1'b1;
    end

endmodule

// File: tb/tb_ppu_mem_loader.sv
// Bench for ppu_mem_loader with the package listing ROM beside it.
// Stimulus pushes expected memory accesses and pass results into queues;
// a negedge monitor pops and compares whenever an access is accepted or
// done rises. Cycle numbers are relative to the cycle start is high.
module tb_ppu_mem_loader;
  import ppu_mem_pkg::*;

  localparam int NUM_CH = 2, CH_W = 2, ADDR_W = 16, DATA_W = 8;
  localparam int LIST_AW = 8, ERR_W = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic [LIST_AW:0] num_entries = '0;
  logic busy, done;
  logic [ERR_W-1:0] err_count;
  logic [LIST_AW-1:0] first_err_idx, list_addr;
  logic [ENTRY_W-1:0] list_data;
  logic [NUM_CH-1:0] mem_wr_en, mem_rd_en;
  logic [NUM_CH-1:0] mem_ready = '1;
  logic [NUM_CH-1:0][ADDR_W-1:0] mem_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] mem_wdata, mem_rdata;

  ppu_mem_list_rom #(.AW(LIST_AW), .W(ENTRY_W)) u_rom (
    .clk(clk), .addr(list_addr), .data(list_data)
  );

  ppu_mem_loader #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .LIST_AW(LIST_AW), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_entries(num_entries),
    .busy(busy), .done(done), .err_count(err_count), .first_err_idx(first_err_idx),
    .list_addr(list_addr), .list_data(list_data),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0;
  int errors = 0, checks = 0;
  bit corrupt = 1'b0;
  bit done_q = 1'b0;

  typedef struct { bit rd; int ch; int addr; int data; int cyc; } txn_t;
  typedef struct { int cyc; int err; int first; } pass_t;
  txn_t  exp_q[$];
  pass_t pass_q[$];
  txn_t  mon_t;
  pass_t mon_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents as left by a load of entries 0..2; corrupt knocks out 16'h2000
  function automatic logic [7:0] mem_val(input int ch, input logic [15:0] a);
    if (ch == 0 && a == 16'h0000) return 8'hFF;
    if (ch == 0 && a == 16'h2000) return corrupt ? 8'h00 : 8'h01;
    if (ch == 1 && a == 16'h0005) return 8'h01;
    return 8'hEE;
  endfunction

  always @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (mem_rd_en[c] && mem_ready[c]) mem_rdata[c] <= mem_val(c, mem_addr[c]);

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if ((mem_wr_en | mem_rd_en) != '0)
        chk("strobe_onehot", 32'($countones({mem_wr_en, mem_rd_en})), 32'd1);
      for (int c = 0; c < NUM_CH; c++) begin
        if ((mem_wr_en[c] || mem_rd_en[c]) && mem_ready[c]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn: ch%0d addr %h at cycle %0d, expected no access",
                     c, mem_addr[c], cyc - t0);
          end else begin
            mon_t = exp_q.pop_front();
            chk("txn_rd", 32'(mem_rd_en[c]), 32'(mon_t.rd));
            chk("txn_ch", c, mon_t.ch);
            chk("txn_addr", 32'(mem_addr[c]), mon_t.addr);
            if (!mon_t.rd) chk("txn_wdata", 32'(mem_wdata[c]), mon_t.data);
            chk("txn_cycle", cyc - t0, mon_t.cyc);
          end
        end
      end
      if (done && !done_q) begin
        if (pass_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: at cycle %0d, expected no completion", cyc - t0);
        end else begin
          mon_p = pass_q.pop_front();
          chk("done_cycle", cyc - t0, mon_p.cyc);
          chk("err_count", 32'(err_count), mon_p.err);
          chk("first_err_idx", 32'(first_err_idx), mon_p.first);
        end
      end
    end
    done_q <= done;
  end

  task automatic push_txn(input bit rd, input int ch, input int addr, input int data, input int c);
    txn_t t;
    t.rd = rd; t.ch = ch; t.addr = addr; t.data = data; t.cyc = c;
    exp_q.push_back(t);
  endtask

  task automatic push_pass(input int c, input int e, input int f);
    pass_t p;
    p.cyc = c; p.err = e; p.first = f;
    pass_q.push_back(p);
  endtask

  // Returns #1 into cycle 1 of the pass
  task automatic start_pass(input bit m, input int n);
    @(posedge clk); #1;
    start = 1'b1; mode = m; num_entries = (LIST_AW+1)'(n);
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: done still %0b after %0d cycles, expected 1", done, n);
    end
  endtask

  task automatic push_load3(input int c0, input int c1, input int c2);
    push_txn(0, 0, 'h0000, 'hFF, c0);
    push_txn(0, 0, 'h2000, 'h01, c1);
    push_txn(0, 1, 'h0005, 'h01, c2);
  endtask

  task automatic chk_hold();
    chk("bp_wr_en", 32'(mem_wr_en), 32'd1);
    chk("bp_addr", 32'(mem_addr[0]), 32'h0000);
    chk("bp_wdata", 32'(mem_wdata[0]), 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_wr_en", 32'(mem_wr_en), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_first", 32'(first_err_idx), 0);
    chk("rst_list_addr", 32'(list_addr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    rst = 1'b0;

    // Load three entries, ready always high
    push_load3(2, 4, 6);
    push_pass(7, 0, 0);
    start_pass(0, 3);
    chk("load_busy", 32'(busy), 1);
    wait_done();

    // Verify with 16'h2000 reading back 00
    corrupt = 1'b1;
    push_txn(1, 0, 'h0000, 0, 2);
    push_txn(1, 0, 'h2000, 0, 5);
    push_txn(1, 1, 'h0005, 0, 8);
    push_pass(10, 1, 1);
    start_pass(1, 3);
    wait_done();

    // Reset while entry 2 is reading
    push_txn(1, 0, 'h0000, 0, 2);
    push_txn(1, 0, 'h2000, 0, 5);
    start_pass(1, 3);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_rd_en", 32'(mem_rd_en), 32'b10);
    chk("pre_rst_err", 32'(err_count), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
    chk("mid_rst_wr_en", 32'(mem_wr_en), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    corrupt = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_partial_done", 32'(done), 0);

    // Zero entries: done at cycle 1, no strobes
    push_pass(1, 0, 0);
    start_pass(0, 0);
    chk("zero_busy", 32'(busy), 0);
    wait_done();

    // Invalid channel at entry 3
    push_load3(2, 4, 6);
    push_pass(9, 1, 3);
    start_pass(0, 4);
    wait_done();

    // Backpressure on channel 0 during entry 0 (ready low cycles 2..5)
    push_load3(6, 8, 10);
    push_pass(11, 0, 0);
    start_pass(0, 3);
    mem_ready[0] = 1'b0;
    @(negedge clk);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk_hold();
    end
    @(posedge clk); #1;
    mem_ready[0] = 1'b1;
    @(negedge clk);
    chk_hold();
    wait_done();

    // Start while done is accepted; start while busy is ignored
    push_load3(2, 4, 6);
    push_pass(7, 0, 0);
    start_pass(0, 3);
    chk("done_clears", 32'(done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; mode = 1'b1; num_entries = '0;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("txn_queue_empty", exp_q.size(), 0);
    chk("pass_queue_empty", pass_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ppu_mem_loader.md
Name: ppu_mem_loader

Overview:
- Parametrised preload/verify engine for PPU memories (VRAM, sprite RAM, and future palette RAM).
- Walks a listing ROM of {channel, address, value} entries and issues one write per entry to the selected memory channel.
- In verify mode it reads each location back instead, compares it with the listed value and records mismatches.
- Sits between a synthesizable listing ROM and the PPU memory write ports, replacing static test-bench listings with a reusable hardware block.

Parameters:
- NUM_CH, 2: number of memory channels (ch 0 = VRAM, ch 1 = sprite RAM).
- CH_W, 2: width of the entry channel field; must satisfy 2^CH_W >= NUM_CH.
- ADDR_W, 16: memory address width.
- DATA_W, 8: memory data width.
- LIST_AW, 8: listing ROM address width (maximum 2^LIST_AW entries).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a pass; ignored while busy
- mode  in  1  0 = load (write), 1 = verify (read and compare); sampled on the accepted start
- num_entries  in  LIST_AW+1  number of listing entries to process; sampled on start
- busy  out  1  pass in progress
- done  out  1  high from pass completion until the next accepted start
- err_count  out  ERR_W  saturating count of mismatches plus invalid-channel entries
- first_err_idx  out  LIST_AW  listing index of the first error in the pass
- list_addr  out  LIST_AW  listing ROM address
- list_data  in  CH_W+ADDR_W+DATA_W  entry {ch, addr, data}, valid one cycle after list_addr
- mem_wr_en  out  NUM_CH  per-channel write strobe
- mem_rd_en  out  NUM_CH  per-channel read strobe
- mem_addr  out  NUM_CH x ADDR_W  per-channel address
- mem_wdata  out  NUM_CH x DATA_W  per-channel write data
- mem_rdata  in  NUM_CH x DATA_W  per-channel read data, valid the cycle after an accepted read
- mem_ready  in  NUM_CH  per-channel accept; a strobe is accepted in any cycle where strobe and ready are both high

Behaviour:
- Reset (asynchronous, immediate): state IDLE; busy, done, all strobes = 0; mem_addr, mem_wdata, list_addr, err_count, first_err_idx = 0.
- A reset asserted mid-pass drops all strobes at once and abandons the pass with no partial done.
- Index register idx, LIST_AW+1 bits, holds the current listing entry.
- FSM states: IDLE, FETCH, ISSUE, CHECK, DONE.
- IDLE:
  - On start, latch mode and num_entries; clear err_count, idx, first_err_idx and done; busy = 1.
  - If num_entries == 0, go to DONE, else go to FETCH.
- FETCH: list_addr = idx; wait one cycle for ROM data, then go to ISSUE.
- ISSUE:
  - Decode ch = list_data[MSBs].
  - If ch >= NUM_CH: no strobe, count an error, go to next-entry handling.
  - Otherwise assert wr_en[ch] (load) or rd_en[ch] (verify) with addr/wdata, held stable until mem_ready[ch].
  - Load: the accepting cycle goes to next-entry handling.
  - Verify: the accepting cycle goes to CHECK.
- CHECK: compare mem_rdata[ch] with the entry data; on mismatch count an error; go to next-entry handling.
- Next-entry handling: idx + 1; if the new idx == num_entries go to DONE, else go to FETCH.
- DONE: busy = 0, done = 1; return to IDLE in the same cycle so a new start is accepted from the next cycle onward.
- Errors:
  - err_count saturates at 2^ERR_W - 1.
  - first_err_idx is captured only when err_count transitions from 0.
- Throughput with ready always high:
  - Load: 2 cycles per entry.
  - Verify: 3 cycles per entry.
  - Total pass latency = start + per-entry cycles × N + 1 cycle until done rises.
- At most one strobe bit is high in any cycle; idle channels hold addr/wdata at their last values.
- start while busy: ignored, no effect.
- start while done: accepted; done clears on the next cycle.

Decomposition:
- Package ppu_mem_pkg holds:
  - the channel index constants (CH_VRAM = 0, CH_SPRAM = 1, CH_PAL = 2);
  - the loader_state_t enum;
  - a function that packs {ch, addr, data} into an entry word, shared by ROM generation and benches.
- Sub-module ppu_mem_list_rom is a parametrised synchronous ROM with 1-cycle latency, initialised from a package constant array. It is instantiated beside the loader, not inside it.

Test Plan:
- Load 3 entries {0,16'h0000,8'hFF}, {0,16'h2000,8'h01}, {1,16'h0005,8'h01}, ready high:
  - writes appear on cycles 2, 4 and 6 after start;
  - ch1 addr = 16'h0005, data = 8'h01;
  - done rises at cycle 7; err_count = 0.
- Verify the same list with rdata returning 8'h00 for 16'h2000:
  - err_count = 1; first_err_idx = 1; the other entries match.
- Backpressure: mem_ready[0] low for 4 cycles during entry 0 → wr_en[0], addr and wdata held stable for 5 cycles; exactly one write is accepted.
- Invalid channel: NUM_CH = 2, entry ch = 3 → no strobe on any channel, err_count = 1, pass completes.
- num_entries = 0 → done at cycle 1 with no strobes; start while busy → ignored.
- Reset asserted mid-pass at entry 2 → strobes drop in the same cycle; busy = 0, done = 0, err_count = 0.
